instr_fetch_issue: RTL

- Producer side of the 32-bit instruction interface consumed by the control unit.
- Holds the program counter and fetches instruction words from instruction memory over a req/ack port.
- Issues each word to the control unit over a valid/ready handshake.
- Accepts branch/jump redirects and stops on a halt word.

---
 rtl/instr_fetch_issue.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/instr_fetch_issue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : instr_fetch_issue                                               |
// | Brief    : PC holder, req/ack instruction fetch and valid/ready issue.     |
// |            Optional perf counters via `define IFETCH_PERF_COUNTERS_EN.     |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module instr_fetch_issue #(
  parameter int                     SIZE       = 32,
  parameter int                     PC_WIDTH   = 16,
  parameter logic [PC_WIDTH-1:0]    RESET_PC   = '0,
  parameter logic [SIZE-1:0]        HALT_INSTR = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  output logic                mem_req,
  output logic [PC_WIDTH-1:0] mem_addr,
  input  logic                mem_ack,
  input  logic [SIZE-1:0]     mem_data,
  output logic                instr_valid,
  input  logic                instr_ready,
  output logic [SIZE-1:0]     instruction,
  output logic [PC_WIDTH-1:0] instr_pc,
  input  logic                redirect,
  input  logic [PC_WIDTH-1:0] redirect_pc,
`ifdef IFETCH_PERF_COUNTERS_EN
  output logic [31:0]         perf_issued,
  output logic [31:0]         perf_stall,
`endif
  output logic                halted
);

  localparam logic [PC_WIDTH-1:0] c_word_mask = ~PC_WIDTH'(3);
  localparam logic [PC_WIDTH-1:0] c_reset_pc  = RESET_PC & c_word_mask;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_ISSUE = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t              r_state;
  logic [PC_WIDTH-1:0] r_pc;
  logic                r_drop;

  logic [PC_WIDTH-1:0] w_redir_pc;
  logic [PC_WIDTH-1:0] w_pc_inc;

  assign w_redir_pc = redirect_pc & c_word_mask;
  assign w_pc_inc   = r_pc + PC_WIDTH'(4);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_pc        <= c_reset_pc;
      r_drop      <= 1'b0;
      mem_req     <= 1'b0;
      mem_addr    <= c_reset_pc;
      instr_valid <= 1'b0;
      instruction <= '0;
      instr_pc    <= '0;
      halted      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (redirect) r_pc <= w_redir_pc;
          if (start) begin
            r_state  <= S_FETCH;
            mem_req  <= 1'b1;
            mem_addr <= redirect ? w_redir_pc : r_pc;
          end
        end

        S_FETCH: begin
          if (!mem_req) begin
            // One idle cycle after a discarded response; launch the next request.
            mem_req  <= 1'b1;
            mem_addr <= redirect ? w_redir_pc : r_pc;
            if (redirect) r_pc <= w_redir_pc;
          end else if (mem_ack) begin
            mem_req <= 1'b0;
            if (r_drop || redirect) begin
              r_drop <= 1'b0;
              if (redirect) r_pc <= w_redir_pc;
            end else if (mem_data == HALT_INSTR) begin
              halted  <= 1'b1;
              r_state <= S_HALT;
            end else begin
              instruction <= mem_data;
              instr_pc    <= r_pc;
              r_pc        <= w_pc_inc;
              instr_valid <= 1'b1;
              r_state     <= S_ISSUE;
            end
          end else if (redirect) begin
            // Request stays in flight; its response will be thrown away.
            r_pc   <= w_redir_pc;
            r_drop <= 1'b1;
          end
        end

        S_ISSUE: begin
          if (redirect || instr_ready) begin
            instr_valid <= 1'b0;
            r_state     <= S_FETCH;
            mem_req     <= 1'b1;
            mem_addr    <= redirect ? w_redir_pc : r_pc;
            if (redirect) r_pc <= w_redir_pc;
          end
        end

        S_HALT: begin
          if (redirect) begin
            halted   <= 1'b0;
            r_pc     <= w_redir_pc;
            r_state  <= S_FETCH;
            mem_req  <= 1'b1;
            mem_addr <= w_redir_pc;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef IFETCH_PERF_COUNTERS_EN
  logic w_stall;
  assign w_stall = ((r_state == S_FETCH) && !mem_ack) ||
                   ((r_state == S_ISSUE) && !instr_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_issued <= '0;
      perf_stall  <= '0;
    end else begin
      if (instr_valid && instr_ready && (perf_issued != 32'hFFFF_FFFF))
        perf_issued <= perf_issued + 32'd1;
      if (w_stall && (perf_stall != 32'hFFFF_FFFF))
        perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule
`default_nettype wire
